// File: rtl/sig_gen_sweep_ctrl.sv
// rtl/sig_gen_sweep_ctrl.sv - sweep scheduler for the signal generator: key debounce, config regs, sweep FSM
module sig_gen_sweep_ctrl #(
   parameter int DB_CNT = 1000000,
   parameter int PRESC  = 50000,
   parameter int F_MIN  = 1,
   parameter int F_MAX  = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_start,
   input  logic        key_wave,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [5:0]  freq_word,
   output logic [1:0]  wave_sel,
   output logic [3:0]  amp,
   output logic        sweep_busy,
   output logic        step_pulse,
   output logic        sweep_done
);

   localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);
   localparam logic [PW-1:0]  P_LAST  = PW'(PRESC - 1);
   // The LOAD/STEP cycle itself is prescaler cycle 0, so counting resumes at 1
   localparam logic [PW-1:0]  P_INIT  = (PRESC == 1) ? '0 : PW'(1);
   localparam logic [15:0]    D_INIT  = (PRESC == 1) ? 16'd1 : 16'd0;
   localparam logic [5:0]     FMIN6   = 6'(F_MIN);
   localparam logic [5:0]     FMAX6   = 6'(F_MAX);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_STEP, S_DONE} state_t;

   // index 0 = start key, index 1 = wave key
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          lvl_q, lvl_d, press_q, press_d;
   logic [1:0][DBW-1:0] dbc_q, dbc_d;

   state_t      state_q, state_d;
   logic [5:0]  freq_q, freq_d, f_start_q, f_start_d, f_stop_q, f_stop_d;
   logic [1:0]  wave_q, wave_d, mode_q, mode_d, run_mode_q, run_mode_d;
   logic [3:0]  amp_q, amp_d;
   logic [15:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic        dir_up_q, dir_up_d, busy_q, busy_d, step_q, step_d, done_q, done_d;
   logic [5:0]  lo, hi;
   logic        start_ev, wave_ev, restart, at_end;

   function automatic logic [5:0] clamp_f(input logic [5:0] v);
      if (v < FMIN6)      return FMIN6;
      else if (v > FMAX6) return FMAX6;
      else                return v;
   endfunction

   assign start_ev   = press_q[0];
   assign wave_ev    = press_q[1];
   assign lo         = (f_start_q < f_stop_q) ? f_start_q : f_stop_q;
   assign hi         = (f_start_q < f_stop_q) ? f_stop_q : f_start_q;
   assign freq_word  = freq_q;
   assign wave_sel   = wave_q;
   assign amp        = amp_q;
   assign sweep_busy = busy_q;
   assign step_pulse = step_q;
   assign sweep_done = done_q;

   // Synchronise both keys and accept a new level after DB_CNT differing samples
   always_comb begin
      sync1_d = {key_wave, key_start};
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      press_d = 2'b00;
      dbc_d   = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != lvl_q[i]) begin
            if (dbc_q[i] == DB_LAST) begin
               lvl_d[i]   = sync2_q[i];
               press_d[i] = lvl_q[i];
            end else begin
               dbc_d[i] = dbc_q[i] + 1'b1;
            end
         end
      end
   end

   // Sweep sequencing, wave key handling and configuration writes
   always_comb begin
      state_d    = state_q;
      freq_d     = freq_q;
      f_start_d  = f_start_q;
      f_stop_d   = f_stop_q;
      wave_d     = wave_q;
      mode_d     = mode_q;
      run_mode_d = run_mode_q;
      amp_d      = amp_q;
      dwell_d    = dwell_q;
      dcnt_d     = dcnt_q;
      presc_d    = presc_q;
      dir_up_d   = dir_up_q;
      step_d     = 1'b0;
      restart    = 1'b0;
      at_end     = dir_up_q ? (freq_q == hi) : (freq_q == lo);

      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d    = S_LOAD;
               run_mode_d = mode_q;
            end
            if (wave_ev) wave_d = (wave_q == 2'd2) ? 2'd0 : wave_q + 2'd1;
         end
         S_LOAD: begin
            if (start_ev) begin
               state_d = S_IDLE;
            end else begin
               freq_d   = (run_mode_q == 2'd1) ? hi : lo;
               dir_up_d = (run_mode_q != 2'd1);
               step_d   = 1'b1;
               restart  = 1'b1;
            end
         end
         S_DWELL: begin
            if (start_ev) begin
               state_d = S_IDLE;
            end else if (presc_q == P_LAST) begin
               presc_d = '0;
               if (dcnt_q + 16'd1 == dwell_q) state_d = S_STEP;
               else                           dcnt_d  = dcnt_q + 16'd1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_STEP: begin
            if (start_ev) begin
               state_d = S_IDLE;
            end else if (!at_end) begin
               freq_d  = dir_up_q ? freq_q + 6'd1 : freq_q - 6'd1;
               step_d  = 1'b1;
               restart = 1'b1;
            end else begin
               case (run_mode_q)
                  2'd2: begin
                     freq_d  = lo;
                     step_d  = 1'b1;
                     restart = 1'b1;
                  end
                  2'd3: begin
                     dir_up_d = ~dir_up_q;
                     if (lo != hi) freq_d = dir_up_q ? freq_q - 6'd1 : freq_q + 6'd1;
                     step_d   = 1'b1;
                     restart  = 1'b1;
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (restart) begin
         presc_d = P_INIT;
         dcnt_d  = D_INIT;
         state_d = ((PRESC == 1) && (dwell_q == 16'd1)) ? S_STEP : S_DWELL;
      end

      if (cfg_we) begin
         case (cfg_addr)
            2'd0: if (!busy_q) f_start_d = clamp_f(cfg_wdata[5:0]);
            2'd1: if (!busy_q) f_stop_d  = clamp_f(cfg_wdata[5:0]);
            2'd2: if (!busy_q) dwell_d   = (cfg_wdata == 16'd0) ? 16'd1 : cfg_wdata;
            default: begin
               mode_d = cfg_wdata[9:8];
               wave_d = (cfg_wdata[5:4] == 2'd3) ? 2'd0 : cfg_wdata[5:4];
               amp_d  = (cfg_wdata[3:0] == 4'd0) ? 4'd1 : cfg_wdata[3:0];
            end
         endcase
      end

      busy_d = (state_d == S_LOAD) || (state_d == S_DWELL) || (state_d == S_STEP);
      done_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         lvl_q      <= 2'b11;
         press_q    <= 2'b00;
         dbc_q      <= '0;
         state_q    <= S_IDLE;
         freq_q     <= 6'd1;
         f_start_q  <= 6'd1;
         f_stop_q   <= 6'd50;
         wave_q     <= 2'd0;
         mode_q     <= 2'd0;
         run_mode_q <= 2'd0;
         amp_q      <= 4'd1;
         dwell_q    <= 16'd1000;
         dcnt_q     <= 16'd0;
         presc_q    <= '0;
         dir_up_q   <= 1'b1;
         busy_q     <= 1'b0;
         step_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         lvl_q      <= lvl_d;
         press_q    <= press_d;
         dbc_q      <= dbc_d;
         state_q    <= state_d;
         freq_q     <= freq_d;
         f_start_q  <= f_start_d;
         f_stop_q   <= f_stop_d;
         wave_q     <= wave_d;
         mode_q     <= mode_d;
         run_mode_q <= run_mode_d;
         amp_q      <= amp_d;
         dwell_q    <= dwell_d;
         dcnt_q     <= dcnt_d;
         presc_q    <= presc_d;
         dir_up_q   <= dir_up_d;
         busy_q     <= busy_d;
         step_q     <= step_d;
         done_q     <= done_d;
      end
   end

endmodule
